// File: rtl/pipe_scheduler.sv
// Pipeline control for a four-stage processor: hazard stalls, LI immediate
// sequencing, taken-jump flushes, SYS halt and a saturating stall counter.
module pipe_scheduler (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  if_op,
    input  logic [5:0]  if_d,
    input  logic [3:0]  rr_op,
    input  logic [5:0]  rr_s,
    input  logic [5:0]  rr_d,
    input  logic [3:0]  alu_op,
    input  logic [5:0]  alu_d,
    input  logic [3:0]  rw_op,
    input  logic [5:0]  rw_d,
    input  logic        rw_jump,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        if_en,
    output logic        rr_en,
    output logic        alu_en,
    output logic        if_nop,
    output logic        rr_nop,
    output logic        alu_nop,
    output logic        imm_fetch,
    output logic        halt,
    output logic [15:0] stall_cnt
);
    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] LI_IMM  = 2'd1;
    localparam logic [1:0] HALT_ST = 2'd2;

    localparam logic [3:0] OP_ST = 4'hD;
    localparam logic [3:0] OP_JZ = 4'hE;
    localparam logic [3:0] OP_LI = 4'hF;

    logic [1:0]  state_reg, state_next;
    logic        halt_reg, halt_next;
    logic [15:0] stall_cnt_reg, stall_cnt_next;
    logic        alu_writes, rw_writes, hazard, sys, jump, stall_hit;

    // Fetch-stage dest and register-read opcode carry no scheduling information.
    logic inputs_unused;
    assign inputs_unused = ^{if_d, rr_op};

    // Destinations 0-3 are constant registers, so they never create a hazard.
    assign alu_writes = (alu_op != OP_ST) && (alu_op != OP_JZ) && (alu_d[5:2] != 4'd0);
    assign rw_writes  = (rw_op != OP_ST) && (rw_op != OP_JZ) && (rw_d[5:2] != 4'd0);
    assign hazard = (alu_writes && ((rr_s == alu_d) || (rr_d == alu_d))) ||
                    (rw_writes  && ((rr_s == rw_d)  || (rr_d == rw_d)));
    assign sys  = (rw_op == OP_JZ) && (rw_d == 6'd0);
    assign jump = (rw_op == OP_JZ) && (rw_d != 6'd0) && rw_jump;

    always_comb begin
        pc_we      = 1'b1;
        pc_sel     = 1'b0;
        if_en      = 1'b1;
        rr_en      = 1'b1;
        alu_en     = 1'b1;
        if_nop     = 1'b0;
        rr_nop     = 1'b0;
        alu_nop    = 1'b0;
        imm_fetch  = 1'b0;
        stall_hit  = 1'b0;
        state_next = state_reg;
        halt_next  = halt_reg;
        if (!reset) begin
            state_next = RUN;
        end else if (state_reg == HALT_ST) begin
            pc_we  = 1'b0;
            if_en  = 1'b0;
            rr_en  = 1'b0;
            alu_en = 1'b0;
        end else if (sys) begin
            state_next = HALT_ST;
            halt_next  = 1'b1;
        end else if (jump) begin
            pc_sel     = 1'b1;
            if_nop     = 1'b1;
            rr_nop     = 1'b1;
            alu_nop    = 1'b1;
            state_next = RUN;
        end else if (hazard) begin
            // Freeze fetch and register read; a bubble flows into the ALU stage.
            pc_we     = 1'b0;
            if_en     = 1'b0;
            rr_en     = 1'b0;
            rr_nop    = 1'b1;
            imm_fetch = (state_reg == LI_IMM);
            stall_hit = 1'b1;
        end else if (state_reg == LI_IMM) begin
            imm_fetch  = 1'b1;
            if_nop     = 1'b1;
            state_next = RUN;
        end else if (if_op == OP_LI) begin
            state_next = LI_IMM;
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall_hit && (stall_cnt_reg != 16'hFFFF))
            stall_cnt_next = stall_cnt_reg + 16'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= RUN;
            halt_reg      <= 1'b0;
            stall_cnt_reg <= 16'd0;
        end else begin
            state_reg     <= state_next;
            halt_reg      <= halt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign halt      = halt_reg;
    assign stall_cnt = stall_cnt_reg;
endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler: vector table in RUN, then hand-written
// LI, jump, halt, reset-recovery and counter-saturation sequences.
module tb_pipe_scheduler;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  if_op = '0, rr_op = '0, alu_op = '0, rw_op = '0;
    logic [5:0]  if_d = '0, rr_s = '0, rr_d = '0, alu_d = '0, rw_d = '0;
    logic        rw_jump = 1'b0;
    logic        pc_we, pc_sel, if_en, rr_en, alu_en, if_nop, rr_nop, alu_nop, imm_fetch, halt;
    logic [15:0] stall_cnt;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_cnt = 16'd0;

    // Packed order: pc_we pc_sel if_en rr_en alu_en if_nop rr_nop alu_nop imm_fetch
    localparam logic [8:0] O_DEF   = 9'b1_0_111_000_0;
    localparam logic [8:0] O_STALL = 9'b0_0_001_010_0;
    localparam logic [8:0] O_JMP   = 9'b1_1_111_111_0;
    localparam logic [8:0] O_LI    = 9'b1_0_111_100_1;
    localparam logic [8:0] O_LISTL = 9'b0_0_001_010_1;
    localparam logic [8:0] O_HALT  = 9'b0_0_000_000_0;

    pipe_scheduler dut (
        .clock(clock), .reset(reset),
        .if_op(if_op), .if_d(if_d),
        .rr_op(rr_op), .rr_s(rr_s), .rr_d(rr_d),
        .alu_op(alu_op), .alu_d(alu_d),
        .rw_op(rw_op), .rw_d(rw_d), .rw_jump(rw_jump),
        .pc_we(pc_we), .pc_sel(pc_sel), .if_en(if_en), .rr_en(rr_en), .alu_en(alu_en),
        .if_nop(if_nop), .rr_nop(rr_nop), .alu_nop(alu_nop), .imm_fetch(imm_fetch),
        .halt(halt), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [3:0] if_op;
        logic [5:0] rr_s, rr_d;
        logic [3:0] alu_op;
        logic [5:0] alu_d;
        logic [3:0] rw_op;
        logic [5:0] rw_d;
        logic       rw_jump;
        logic [8:0] exp_out;
        logic       exp_inc;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(string n, logic [3:0] iop, logic [5:0] s, logic [5:0] d,
                                logic [3:0] aop, logic [5:0] ad, logic [3:0] wop,
                                logic [5:0] wd, logic wj, logic [8:0] eo, logic ei);
        vec_t v;
        v.name = n; v.if_op = iop; v.rr_s = s; v.rr_d = d; v.alu_op = aop; v.alu_d = ad;
        v.rw_op = wop; v.rw_d = wd; v.rw_jump = wj; v.exp_out = eo; v.exp_inc = ei;
        return v;
    endfunction

    function automatic logic [8:0] outs();
        return {pc_we, pc_sel, if_en, rr_en, alu_en, if_nop, rr_nop, alu_nop, imm_fetch};
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic drive(logic [3:0] iop, logic [5:0] s, logic [5:0] d, logic [3:0] aop,
                         logic [5:0] ad, logic [3:0] wop, logic [5:0] wd, logic wj);
        if_op = iop; rr_op = 4'h0; rr_s = s; rr_d = d; alu_op = aop; alu_d = ad;
        rw_op = wop; rw_d = wd; rw_jump = wj; if_d = 6'd0;
    endtask

    task automatic idle();
        drive(4'h0, 6'd0, 6'd0, 4'h0, 6'd0, 4'h0, 6'd0, 1'b0);
    endtask

    // Advance one edge; inputs change 1 time unit after it, checks happen at the falling edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        chk("async_rst_halt", {15'd0, halt}, 16'd0);
        chk("async_rst_cnt", stall_cnt, 16'd0);
        exp_cnt = 16'd0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        vecs[0] = mk("idle",           4'h0, 6'd0, 6'd0, 4'h0, 6'd0, 4'h0, 6'd0, 1'b0, O_DEF,   1'b0);
        vecs[1] = mk("haz_alu_s5",     4'h0, 6'd5, 6'd0, 4'h0, 6'd5, 4'h0, 6'd0, 1'b0, O_STALL, 1'b1);
        vecs[2] = mk("const_reg2",     4'h0, 6'd2, 6'd0, 4'h1, 6'd2, 4'h0, 6'd0, 1'b0, O_DEF,   1'b0);
        vecs[3] = mk("haz_rw_d9",      4'h0, 6'd0, 6'd9, 4'h0, 6'd0, 4'h3, 6'd9, 1'b0, O_STALL, 1'b1);
        vecs[4] = mk("st_nonwriter",   4'h0, 6'd9, 6'd0, 4'hD, 6'd9, 4'h0, 6'd0, 1'b0, O_DEF,   1'b0);
        vecs[5] = mk("jz_not_taken",   4'h0, 6'd9, 6'd0, 4'h0, 6'd0, 4'hE, 6'd9, 1'b0, O_DEF,   1'b0);
        vecs[6] = mk("haz_dest4",      4'h0, 6'd4, 6'd0, 4'h2, 6'd4, 4'h0, 6'd0, 1'b0, O_STALL, 1'b1);
        vecs[7] = mk("rw_dest3",       4'h0, 6'd3, 6'd0, 4'h0, 6'd0, 4'h1, 6'd3, 1'b0, O_DEF,   1'b0);
        vecs[8] = mk("jump_over_haz",  4'h0, 6'd5, 6'd0, 4'h0, 6'd5, 4'hE, 6'd7, 1'b1, O_JMP,   1'b0);
        vecs[9] = mk("jump_alone",     4'h0, 6'd0, 6'd0, 4'h0, 6'd0, 4'hE, 6'd1, 1'b1, O_JMP,   1'b0);

        // Reset held low with a hazard present: outputs must still show the run pattern.
        drive(4'h0, 6'd5, 6'd0, 4'h0, 6'd5, 4'h0, 6'd0, 1'b0);
        #3;
        chk("rst_outs", {7'd0, outs()}, {7'd0, O_DEF});
        chk("rst_halt", {15'd0, halt}, 16'd0);
        chk("rst_cnt", stall_cnt, 16'd0);
        tick();
        reset = 1'b1;
        idle();

        foreach (vecs[i]) begin
            drive(vecs[i].if_op, vecs[i].rr_s, vecs[i].rr_d, vecs[i].alu_op, vecs[i].alu_d,
                  vecs[i].rw_op, vecs[i].rw_d, vecs[i].rw_jump);
            #4;
            chk({vecs[i].name, "_outs"}, {7'd0, outs()}, {7'd0, vecs[i].exp_out});
            if (vecs[i].exp_inc) exp_cnt = exp_cnt + 16'd1;
            tick();
            chk({vecs[i].name, "_cnt"}, stall_cnt, exp_cnt);
        end

        // LI: immediate word follows, then back to RUN.
        drive(4'hF, 6'd0, 6'd0, 4'h0, 6'd0, 4'h0, 6'd0, 1'b0);
        #4 chk("li_issue", {7'd0, outs()}, {7'd0, O_DEF});
        tick();
        drive(4'h3, 6'd0, 6'd0, 4'h0, 6'd0, 4'h0, 6'd0, 1'b0);
        #4 chk("li_imm", {7'd0, outs()}, {7'd0, O_LI});
        tick();
        idle();
        #4 chk("li_back_run", {7'd0, outs()}, {7'd0, O_DEF});
        tick();

        // LI stalled in the immediate cycle stays in LI_IMM.
        drive(4'hF, 6'd0, 6'd0, 4'h0, 6'd0, 4'h0, 6'd0, 1'b0);
        tick();
        drive(4'h0, 6'd6, 6'd0, 4'h0, 6'd6, 4'h0, 6'd0, 1'b0);
        #4 chk("li_stalled", {7'd0, outs()}, {7'd0, O_LISTL});
        exp_cnt = exp_cnt + 16'd1;
        tick();
        chk("li_stall_cnt", stall_cnt, exp_cnt);
        idle();
        #4 chk("li_after_stall", {7'd0, outs()}, {7'd0, O_LI});
        tick();
        #4 chk("li_stall_run", {7'd0, outs()}, {7'd0, O_DEF});
        tick();

        // Taken jump abandons LI_IMM.
        drive(4'hF, 6'd0, 6'd0, 4'h0, 6'd0, 4'h0, 6'd0, 1'b0);
        tick();
        drive(4'h0, 6'd0, 6'd0, 4'h0, 6'd0, 4'hE, 6'd8, 1'b1);
        #4 chk("li_jump", {7'd0, outs()}, {7'd0, O_JMP});
        tick();
        idle();
        #4 chk("li_jump_run", {7'd0, outs()}, {7'd0, O_DEF});
        tick();

        // SYS halts; hazards during HALT neither stall nor count.
        drive(4'h0, 6'd0, 6'd0, 4'h0, 6'd0, 4'hE, 6'd0, 1'b0);
        #4 chk("sys_pre_halt", {15'd0, halt}, 16'd0);
        tick();
        chk("sys_halt", {15'd0, halt}, 16'd1);
        drive(4'h0, 6'd5, 6'd0, 4'h0, 6'd5, 4'h0, 6'd0, 1'b0);
        #4 chk("halt_outs", {7'd0, outs()}, {7'd0, O_HALT});
        repeat (3) tick();
        chk("halt_held", {15'd0, halt}, 16'd1);
        chk("halt_cnt_frozen", stall_cnt, exp_cnt);
        idle();
        do_reset();
        #3 chk("halt_exit_outs", {7'd0, outs()}, {7'd0, O_DEF});
        chk("halt_exit_flag", {15'd0, halt}, 16'd0);
        tick();

        // Reset asserted in LI_IMM returns to RUN.
        drive(4'hF, 6'd0, 6'd0, 4'h0, 6'd0, 4'h0, 6'd0, 1'b0);
        tick();
        idle();
        do_reset();
        tick();
        #3 chk("li_rst_run", {7'd0, outs()}, {7'd0, O_DEF});

        // Saturation: 65535 stalls reach FFFF, further stalls hold it.
        drive(4'h0, 6'd7, 6'd0, 4'h0, 6'd7, 4'h0, 6'd0, 1'b0);
        repeat (65534) @(posedge clock);
        #1 chk("sat_minus1", stall_cnt, 16'hFFFE);
        tick();
        chk("sat_reach", stall_cnt, 16'hFFFF);
        repeat (5) tick();
        chk("sat_hold", stall_cnt, 16'hFFFF);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pipe_scheduler.md
PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

Interface
REQ-001 SHALL have port: clock  in  1  single processor clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low; reset is asserted while low.
REQ-003 SHALL have ports: if_op in 4, if_d in 6  opcode and dest of the word in the fetch stage.
REQ-004 SHALL have ports: rr_op in 4, rr_s in 6, rr_d in 6  instruction in the register-read stage.
REQ-005 SHALL have ports: alu_op in 4, alu_d in 6  instruction in the ALU/data-mem stage.
REQ-006 SHALL have ports: rw_op in 4, rw_d in 6, rw_jump in 1  instruction in register-store stage; rw_jump = branch condition true.
REQ-007 SHALL have outputs, 1 bit each: pc_we, pc_sel (0 = increment, 1 = jump target), if_en, rr_en, alu_en, if_nop, rr_nop, alu_nop, imm_fetch, halt.
REQ-008 SHALL have output stall_cnt  out  16  saturating count of hazard-stall cycles.

Function
REQ-009 SHALL treat opcode 4'hD (ST) and 4'hE (JZ/SYS/SZ) as non-writers; all other opcodes write register d.
REQ-010 SHALL ignore dest 0-3 for hazards (constant registers, never written).
REQ-011 SHALL flag hazard when rr_s or rr_d equals alu_d or rw_d of a writer in that stage with dest >= 4.
REQ-012 SHALL define states RUN, LI_IMM, HALT; all outputs are combinational from state and inputs except halt and stall_cnt (registered).
REQ-013 SHALL, in RUN with no event: pc_we=if_en=rr_en=alu_en=1, all nops 0, pc_sel=0, imm_fetch=0.
REQ-014 SHALL, on hazard: pc_we=if_en=rr_en=0, alu_en=1, rr_nop=1 (bubble into ALU stage); stall lasts until hazard clears, at most 2 cycles.
REQ-015 SHALL increment stall_cnt by 1 each hazard-stall cycle, saturating at 16'hFFFF.
REQ-016 SHALL, when if_op = 4'hF (LI) and if_en = 1 in RUN, go to LI_IMM next cycle.
REQ-017 SHALL, in LI_IMM: imm_fetch=1, pc_we=1, if_nop=1 (immediate word never decoded as instruction); return to RUN after one non-stalled cycle; stay in LI_IMM while stalled.
REQ-018 SHALL, when rw_op = 4'hE, rw_d != 0, rw_jump = 1: pc_sel=1, pc_we=1, if_nop=rr_nop=alu_nop=1 same cycle; next state RUN (LI_IMM abandoned).
REQ-019 SHALL, when rw_op = 4'hE and rw_d = 0 (SYS): set halt at next edge, enter HALT.
REQ-020 SHALL, in HALT: pc_we=if_en=rr_en=alu_en=0, nops 0, halt=1, stall_cnt frozen; exit only by reset.
REQ-021 SHALL apply priority: reset > SYS > taken jump > hazard stall > LI sequencing.
REQ-022 SHALL not count stall when a taken jump or SYS coincides with a hazard.
REQ-023 SHALL treat op=0, d=0 (bubble) as non-hazarding in every stage.

Reset
REQ-024 SHALL, while reset low, asynchronously force state=RUN, halt=0, stall_cnt=0.
REQ-025 SHALL drive, during reset, pc_we=if_en=rr_en=alu_en=1, all nops=0, pc_sel=0, imm_fetch=0.
REQ-026 SHALL recover from reset asserted in any state, including LI_IMM and HALT, to RUN at first edge after release.

Verification
REQ-027 SHALL test: rr_op=0 rr_s=5, alu_op=0 alu_d=5 -> rr_en=0, pc_we=0, rr_nop=1 one cycle, stall_cnt 0->1.
REQ-028 SHALL test: rr_s=2, alu_d=2 writer -> no stall, stall_cnt stays 0.
REQ-029 SHALL test: if_op=4'hF in RUN -> next cycle imm_fetch=1, if_nop=1, then RUN.
REQ-030 SHALL test: rw_op=4'hE rw_d=7 rw_jump=1 concurrent with hazard -> pc_sel=1, all three nops=1, stall_cnt unchanged.
REQ-031 SHALL test: rw_op=4'hE rw_d=0 -> halt=1 next edge, all enables 0 held; reset low then high -> halt=0, RUN.
REQ-032 SHALL test: 65536 forced stall cycles -> stall_cnt holds 16'hFFFF.
